stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Top-level sequencing controller for the stopwatch counter. Debounces the raw Basys3 push-buttons, runs the stopwatch state machine, and drives the counter's `init_regs` and `count_enabled` controls, plus a display-freeze flag for the optional lap function. Sits between the board button pins and the counter/display path in the top module.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: synchronised button level must be stable this many consecutive cycles before being accepted (10 ms at 100 MHz); minimum 2.
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `btn_start_stop`  in  1  raw, asynchronous start/stop button, active-high.
- `btn_clear`  in  1  raw, asynchronous clear button, active-high.
- `btn_lap`  in  1  raw lap button, active-high; ignored unless `STOPWATCH_LAP_EN` is defined.
- `init_regs`  out  1  counter clear; high holds the counter at zero.
- `count_enabled`  out  1  counter advance enable.
- `disp_freeze`  out  1  display mux holds its last latched reading while high.
- `state_leds`  out  2  current state code for LEDs.

## Operation
- Each button passes through a 2-FF synchroniser, then a debouncer. The debounced level toggles only after the synchronised value differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any agreeing cycle resets the stability count.
- A one-cycle press pulse is emitted on each debounced rising edge. Releases generate no event, and holding a button produces exactly one pulse.
- FSM states and codes: IDLE=0, RUN=1, PAUSE=2, LAP=3.
- IDLE: `start_stop` → RUN; `clear` has no effect.
- RUN: `start_stop` → PAUSE; `clear` is ignored; `lap` → LAP.
- PAUSE: `start_stop` → RUN; `clear` → IDLE.
- LAP: `lap` → RUN; `start_stop` → PAUSE; `clear` is ignored.
- Simultaneous pulses: `clear` has highest priority, then `start_stop`, then `lap`. Only the winning event is acted on; the others are discarded, not queued.
- Outputs are registered and decoded from the next state:

  | State | `init_regs` | `count_enabled` | `disp_freeze` |
  |---|---|---|---|
  | IDLE | 1 | 0 | 0 |
  | RUN | 0 | 1 | 0 |
  | PAUSE | 0 | 0 | 0 |
  | LAP | 0 | 1 | 1 |

- `init_regs` and `count_enabled` are never both high.
- `state_leds` equals the state code.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - state = IDLE
  - `init_regs`=1, `count_enabled`=0, `disp_freeze`=0, `state_leds`=0
  - synchronisers, debounce levels and counters cleared to 0
- A button held high during reset release is seen as a new press once it is debounced.
- Reset asserted mid-operation overrides everything on that edge, including a pending press pulse.
- Press latency: outputs change exactly `DEBOUNCE_CYCLES` + 3 rising edges after the first edge that samples the new raw level.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles produce no pulse and no state change.
- The debounce counter saturates; it never wraps.
- Each output changes at most once per clock.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - `btn_lap` has its own debouncer.
  - The LAP state is reachable.
  - `disp_freeze` behaves as described in Operation.
- `STOPWATCH_LAP_EN` undefined:
  - The lap debouncer and LAP state are removed.
  - `btn_lap` is unused.
  - `disp_freeze` is tied to 0.
  - The FSM has IDLE/RUN/PAUSE only; the `state_leds` encoding is unchanged.

## Structure
- Package `stopwatch_pkg` holds:
  - state code constants (IDLE/RUN/PAUSE/LAP)
  - state width (2)
  - `DEBOUNCE_CYCLES` default value
- Sub-module `btn_debounce` contains the synchroniser, debounce counter and rising-edge pulse. It is instantiated once per button and has parameter `DEBOUNCE_CYCLES`.
- The FSM and output registers live in `stopwatch_ctrl`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset:** hold `rst_n`=0 for 3 cycles with `btn_start_stop`=1 → `init_regs`=1, `count_enabled`=0, `state_leds`=0. After release and debounce, → RUN.
- **Start/stop cycle:** press `start_stop` for 10 cycles → `count_enabled`=1 exactly 7 edges after the raw rise. Release, press again → PAUSE (`count_enabled`=0, `state_leds`=2). Press again → RUN.
- **Debounce reject:** pulses on `btn_start_stop` of 3 cycles high / 1 cycle low, repeated 5 times → no state change.
- **Clear:** `clear` in RUN → stays RUN. `clear` in PAUSE → IDLE with `init_regs`=1 on the same edge that `state_leds` becomes 0.
- **Priority:** in PAUSE, `start_stop` and `clear` rise on the same edge → IDLE with no pulse to RUN. Holding both buttons afterwards produces no further transitions.
- **Lap (`STOPWATCH_LAP_EN` defined):** `lap` in RUN → `disp_freeze`=1, `count_enabled`=1. `start_stop` → PAUSE with `disp_freeze`=0. Without the macro, `lap` in RUN → no change and `disp_freeze` stays 0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state codes, state width,
// default debounce length and the state-to-control decode.
package stopwatch_pkg;

  localparam int STATE_W             = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic init_regs;
    logic count_enabled;
    logic disp_freeze;
  } ctrl_out_t;

  // Counter/display controls implied by a state; clear and advance are
  // mutually exclusive by construction.
  function automatic ctrl_out_t decode_outputs(input state_t s);
    ctrl_out_t o;
    o = '{init_regs: 1'b0, count_enabled: 1'b0, disp_freeze: 1'b0};
    case (s)
      ST_IDLE:  o.init_regs     = 1'b1;
      ST_RUN:   o.count_enabled = 1'b1;
      ST_LAP: begin
        o.count_enabled = 1'b1;
        o.disp_freeze   = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// btn_debounce: 2-FF synchroniser, saturating stability counter and
// rising-edge press pulse for one raw push-button.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then accept a new level only after DEBOUNCE_CYCLES
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      level_q <= level;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // Final disagreeing sample: accept the level and restart; the count
        // therefore never passes CNT_MAX and cannot wrap.
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Press pulse is combinational from the debounced rise so the FSM can
  // register it on the very next edge; releases produce nothing.
  always_comb begin
    press = level & ~level_q;
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounces the board buttons and sequences the stopwatch
// counter (IDLE/RUN/PAUSE, plus LAP when STOPWATCH_LAP_EN is defined).
// Without STOPWATCH_LAP_EN the lap button is ignored and disp_freeze is 0.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_start_stop,
  input  logic               btn_clear,
  input  logic               btn_lap,
  output logic               init_regs,
  output logic               count_enabled,
  output logic               disp_freeze,
  output logic [STATE_W-1:0] state_leds
);

  logic      ss_press;
  logic      clr_press;
  logic      lap_press;
  logic      ev_clear;
  logic      ev_ss;
  logic      ev_lap;
  state_t    state;
  state_t    state_nxt;
  ctrl_out_t out_nxt;
  ctrl_out_t out_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_start_stop),
    .press (ss_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clear),
    .press (clr_press)
  );

`ifdef STOPWATCH_LAP_EN
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_lap),
    .press (lap_press)
  );
`else
  logic lap_unused;
  assign lap_unused = btn_lap;
  assign lap_press  = 1'b0;
`endif

  // State and output registers; outputs come from the next state so they
  // move on the same edge as the state code.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      out_q <= '{init_regs: 1'b1, count_enabled: 1'b0, disp_freeze: 1'b0};
    end else begin
      state <= state_nxt;
      out_q <= out_nxt;
    end
  end

  // Next state: arbitrate simultaneous presses (clear > start/stop > lap),
  // then apply only the winner; losers are dropped.
  always_comb begin
    ev_clear  = clr_press;
    ev_ss     = ss_press & ~clr_press;
    ev_lap    = lap_press & ~clr_press & ~ss_press;
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (ev_ss) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (ev_ss)       state_nxt = ST_PAUSE;
        else if (ev_lap) state_nxt = ST_LAP;
      end
      ST_PAUSE: begin
        if (ev_clear)    state_nxt = ST_IDLE;
        else if (ev_ss)  state_nxt = ST_RUN;
      end
`ifdef STOPWATCH_LAP_EN
      ST_LAP: begin
        if (ev_ss)       state_nxt = ST_PAUSE;
        else if (ev_lap) state_nxt = ST_RUN;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode of the next state; freeze is forced low without lap support.
  always_comb begin
    out_nxt = decode_outputs(state_nxt);
`ifndef STOPWATCH_LAP_EN
    out_nxt.disp_freeze = 1'b0;
`endif
  end

  assign init_regs     = out_q.init_regs;
  assign count_enabled = out_q.count_enabled;
  assign disp_freeze   = out_q.disp_freeze;
  assign state_leds    = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4: table of button
// presses with expected state/outputs, plus hand sequences for reset,
// exact press latency, glitch rejection, clear timing, priority and lap.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       btn_lap;
  logic       init_regs;
  logic       count_enabled;
  logic       disp_freeze;
  logic [1:0] state_leds;

  int   checks;
  int   failures;
  logic mon_en;

  typedef struct {
    logic       ss;
    logic       clr;
    logic       lap;
    int         cyc;
    logic [1:0] led;
    logic       init;
    logic       cnt;
    logic       frz;
    string      nm;
  } vec_t;

  vec_t vecs[$];

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .btn_lap        (btn_lap),
    .init_regs      (init_regs),
    .count_enabled  (count_enabled),
    .disp_freeze    (disp_freeze),
    .state_leds     (state_leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {led,init,cnt,frz}=%b expected %b", nm, act, exp);
    end
  endtask

  // Expected outputs for a state code, straight from the state/output table.
  task automatic chk_state(input string nm, input logic [1:0] led);
    logic e_init, e_cnt, e_frz;
    e_init = (led == 2'd0);
    e_cnt  = (led == 2'd1) || (led == 2'd3);
    e_frz  = (led == 2'd3);
    chk(nm, {state_leds, init_regs, count_enabled, disp_freeze},
        {led, e_init, e_cnt, e_frz});
  endtask

  // Advance n edges, sampling 1 time unit after each; also checks that clear
  // and advance are never high together.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        checks++;
        if (init_regs && count_enabled) begin
          failures++;
          $display("FAIL exclusive: init_regs=%b count_enabled=%b required not both 1",
                   init_regs, count_enabled);
        end
      end
    end
  endtask

  task automatic press_ss();
    btn_start_stop = 1'b1; tick(10);
    btn_start_stop = 1'b0; tick(10);
  endtask

  task automatic add(input logic ss, input logic clr, input logic lap, input int cyc,
                     input logic [1:0] led, input logic init, input logic cnt,
                     input logic frz, input string nm);
    vec_t v;
    v.ss = ss; v.clr = clr; v.lap = lap; v.cyc = cyc;
    v.led = led; v.init = init; v.cnt = cnt; v.frz = frz; v.nm = nm;
    vecs.push_back(v);
  endtask

  initial begin
    checks = 0; failures = 0; mon_en = 1'b0;
    rst_n = 1'b0; btn_start_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;

    //            ss clr lap cyc  led   init cnt frz
    add(1'b1, 1'b0, 1'b0, 10, 2'd1, 1'b0, 1'b1, 1'b0, "tbl_idle_ss_run");
    add(1'b0, 1'b0, 1'b0, 10, 2'd1, 1'b0, 1'b1, 1'b0, "tbl_release_run");
    add(1'b1, 1'b0, 1'b0, 10, 2'd2, 1'b0, 1'b0, 1'b0, "tbl_run_ss_pause");
    add(1'b0, 1'b0, 1'b0, 10, 2'd2, 1'b0, 1'b0, 1'b0, "tbl_release_pause");
    add(1'b1, 1'b0, 1'b0, 10, 2'd1, 1'b0, 1'b1, 1'b0, "tbl_pause_ss_run");
    add(1'b0, 1'b0, 1'b0, 10, 2'd1, 1'b0, 1'b1, 1'b0, "tbl_release_run2");
    add(1'b0, 1'b1, 1'b0, 10, 2'd1, 1'b0, 1'b1, 1'b0, "tbl_run_clr_ignored");
    add(1'b0, 1'b0, 1'b0, 10, 2'd1, 1'b0, 1'b1, 1'b0, "tbl_release_clr");
    add(1'b1, 1'b0, 1'b0, 10, 2'd2, 1'b0, 1'b0, 1'b0, "tbl_run_ss_pause2");
    add(1'b0, 1'b0, 1'b0, 10, 2'd2, 1'b0, 1'b0, 1'b0, "tbl_release_pause2");
    add(1'b0, 1'b1, 1'b0, 10, 2'd0, 1'b1, 1'b0, 1'b0, "tbl_pause_clr_idle");
    add(1'b0, 1'b0, 1'b0, 10, 2'd0, 1'b1, 1'b0, 1'b0, "tbl_release_idle");
    add(1'b0, 1'b1, 1'b0, 10, 2'd0, 1'b1, 1'b0, 1'b0, "tbl_idle_clr_noeffect");
    add(1'b0, 1'b0, 1'b0, 10, 2'd0, 1'b1, 1'b0, 1'b0, "tbl_release_idle2");
    add(1'b0, 1'b0, 1'b1, 10, 2'd0, 1'b1, 1'b0, 1'b0, "tbl_idle_lap_noeffect");
    add(1'b0, 1'b0, 1'b0, 10, 2'd0, 1'b1, 1'b0, 1'b0, "tbl_release_idle3");

    // Reset held with start/stop pressed, then press seen after release.
    btn_start_stop = 1'b1;
    tick(3);
    mon_en = 1'b1;
    chk_state("reset_hold", 2'd0);
    rst_n = 1'b1;
    tick(6);
    chk_state("rst_release_edge6_idle", 2'd0);
    tick(1);
    chk_state("rst_release_edge7_run", 2'd1);
    btn_start_stop = 1'b0;
    tick(10);
    chk_state("rst_release_held_run", 2'd1);

    // Reset on the edge where a press pulse is pending overrides it.
    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(10);
    chk_state("reset_mid_run_idle", 2'd0);
    btn_start_stop = 1'b1;
    tick(6);
    chk_state("pending_press_edge6", 2'd0);
    rst_n = 1'b0; btn_start_stop = 1'b0;
    tick(1);
    chk_state("reset_over_pending_press", 2'd0);
    rst_n = 1'b1;
    tick(12);
    chk_state("after_reset_no_press", 2'd0);

    // Table of presses.
    foreach (vecs[i]) begin
      btn_start_stop = vecs[i].ss;
      btn_clear      = vecs[i].clr;
      btn_lap        = vecs[i].lap;
      tick(vecs[i].cyc);
      chk(vecs[i].nm, {state_leds, init_regs, count_enabled, disp_freeze},
          {vecs[i].led, vecs[i].init, vecs[i].cnt, vecs[i].frz});
    end
    btn_start_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;

    // Glitch rejection: 3 high / 1 low, five times, from RUN.
    press_ss();
    chk_state("glitch_setup_run", 2'd1);
    for (int g = 0; g < 5; g++) begin
      btn_start_stop = 1'b1; tick(3);
      btn_start_stop = 1'b0; tick(1);
      chk_state("glitch_run_unchanged", 2'd1);
    end
    tick(10);
    chk_state("glitch_after_settle", 2'd1);

    // Exact latency of a press from RUN to PAUSE.
    btn_start_stop = 1'b1;
    tick(6);
    chk_state("latency_edge6_run", 2'd1);
    tick(1);
    chk_state("latency_edge7_pause", 2'd2);
    btn_start_stop = 1'b0;
    tick(10);

    // Clear from PAUSE: init_regs rises on the same edge state_leds goes to 0.
    btn_clear = 1'b1;
    tick(6);
    chk_state("clear_edge6_pause", 2'd2);
    tick(1);
    chk_state("clear_edge7_idle", 2'd0);
    btn_clear = 1'b0;
    tick(10);

    // Priority: start/stop and clear together in PAUSE -> IDLE only.
    press_ss();
    press_ss();
    chk_state("prio_setup_pause", 2'd2);
    btn_start_stop = 1'b1; btn_clear = 1'b1;
    tick(7);
    chk_state("prio_clear_wins", 2'd0);
    for (int h = 0; h < 20; h++) begin
      tick(1);
      chk_state("prio_hold_no_transition", 2'd0);
    end
    btn_start_stop = 1'b0; btn_clear = 1'b0;
    tick(10);
    chk_state("prio_release_idle", 2'd0);

    // Lap handling.
    press_ss();
    chk_state("lap_setup_run", 2'd1);
    btn_lap = 1'b1;
    tick(7);
`ifdef STOPWATCH_LAP_EN
    chk_state("lap_run_to_lap", 2'd3);
    btn_lap = 1'b0; tick(10);
    btn_lap = 1'b1; tick(7);
    chk_state("lap_lap_to_run", 2'd1);
    btn_lap = 1'b0; tick(10);
    btn_lap = 1'b1; tick(7);
    chk_state("lap_run_to_lap2", 2'd3);
`else
    chk_state("lap_disabled_stays_run", 2'd1);
`endif
    btn_lap = 1'b0;
    tick(10);
    btn_start_stop = 1'b1;
    tick(7);
    chk_state("lap_ss_to_pause", 2'd2);
    btn_start_stop = 1'b0;
    tick(10);
    chk_state("lap_final_pause", 2'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
